// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init sequencing states and
// CAS latency limits. Used by the responder and by the controller bench.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_REF   = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_BST   = 3'b110,
        CMD_NOP   = 3'b111
    } cmd_t;

    typedef enum logic [2:0] {
        ST_WAIT_PALL,
        ST_WAIT_REF1,
        ST_WAIT_REF2,
        ST_WAIT_MRS,
        ST_READY
    } init_state_t;

    localparam int CL_MIN  = 2;
    localparam int CL_MAX  = 3;
    localparam int A10_BIT = 10;

    // Only CL 2/3 and single-beat bursts are modelled.
    function automatic logic mode_legal(input logic [2:0] cl, input logic [2:0] bl);
        return ((cl == 3'(CL_MIN)) || (cl == 3'(CL_MAX))) && (bl == 3'b000);
    endfunction

endpackage

// File: rtl/sdram_if.sv
// SDRAM command bus as seen between controller (master) and device (slave).
// The DQ bus is bidirectional and stays a plain port on the device.
interface sdram_if #(
    parameter int BANK_WIDTH    = 2,
    parameter int SDRADDR_WIDTH = 13
);
    logic                     clock_enable;
    logic                     cs_n;
    logic                     ras_n;
    logic                     cas_n;
    logic                     we_n;
    logic [BANK_WIDTH-1:0]    bank_addr;
    logic [SDRADDR_WIDTH-1:0] addr;
    logic                     data_mask_low;
    logic                     data_mask_high;

    modport master (
        output clock_enable, cs_n, ras_n, cas_n, we_n,
        output bank_addr, addr, data_mask_low, data_mask_high
    );

    modport slave (
        input clock_enable, cs_n, ras_n, cas_n, we_n,
        input bank_addr, addr, data_mask_low, data_mask_high
    );
endinterface

// File: rtl/sdram_read_pipe.sv
// Read return pipeline: word, byte masks and valid shift one stage per clock;
// the stage selected by the CAS latency drives the DQ bus.
module sdram_read_pipe
    import sdram_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_data,
    input  logic [1:0]  load_mask,
    input  logic [1:0]  cas_latency,
    output logic [1:0]  drive_en,
    output logic [15:0] drive_data,
    output logic        beat
);
    localparam int DEPTH = CL_MAX;

    logic [DEPTH-1:0] valid_q;
    logic [15:0]      data_q [DEPTH];
    logic [1:0]       mask_q [DEPTH];
    logic [1:0]       sel_mask;

    // Only valid needs reset; flushing it releases DQ immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], load};
        end
    end

    always_ff @(posedge clk) begin
        data_q[0] <= load_data;
        mask_q[0] <= load_mask;
        for (int i = 1; i < DEPTH; i++) begin
            data_q[i] <= data_q[i-1];
            mask_q[i] <= mask_q[i-1];
        end
    end

    always_comb begin
        beat       = valid_q[CL_MIN-1];
        drive_data = data_q[CL_MIN-1];
        sel_mask   = mask_q[CL_MIN-1];
        if (cas_latency == 2'(CL_MAX)) begin
            beat       = valid_q[CL_MAX-1];
            drive_data = data_q[CL_MAX-1];
            sel_mask   = mask_q[CL_MAX-1];
        end
        drive_en = beat ? ~sel_mask : 2'b00;
    end

endmodule

// File: rtl/sdram_responder.sv
// SDRAM device responder: command decode, init sequencing, bank tracking and
// a reduced storage array, with protocol violations reported on cmd_error.
//
// state        | meaning
// ST_WAIT_PALL | after reset, waiting for PRECHARGE all
// ST_WAIT_REF1 | waiting for first REFRESH
// ST_WAIT_REF2 | waiting for second REFRESH
// ST_WAIT_MRS  | waiting for a legal MODE REGISTER SET
// ST_READY     | init complete, ACTIVE/READ/WRITE accepted
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int ROW_WIDTH      = 13,
    parameter int COL_WIDTH      = 9,
    parameter int BANK_WIDTH     = 2,
    parameter int SDRADDR_WIDTH  = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    sdram_if.slave      bus,
    inout  wire  [15:0] data,
    output logic        init_done,
    output logic        cmd_error,
    output logic [15:0] refresh_count
);
    localparam int NUM_BANKS  = 1 << BANK_WIDTH;
    localparam int FULL_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;

    init_state_t state_q, state_d;
    cmd_t        cmd;

    logic [NUM_BANKS-1:0]      bank_open;
    logic [ROW_WIDTH-1:0]      bank_row [NUM_BANKS];
    logic [1:0]                cas_latency;
    logic [15:0]               mem [2**MEM_ADDR_WIDTH];
    logic                      ready, sel_open, auto_pre, read_beat, refresh_seen;
    logic                      err_d, do_act, do_pre, do_ref, do_mrs, do_read, do_write;
    logic [FULL_WIDTH-1:0]     full_addr;
    logic [MEM_ADDR_WIDTH-1:0] mem_idx;
    logic [1:0]                drive_en;
    logic [15:0]               drive_data;
    logic                      unused_addr_bits;

    assign ready            = (state_q == ST_READY);
    assign sel_open         = bank_open[bus.bank_addr];
    assign auto_pre         = bus.addr[A10_BIT];
    assign full_addr        = {bus.bank_addr, bank_row[bus.bank_addr], bus.addr[COL_WIDTH-1:0]};
    assign mem_idx          = full_addr[MEM_ADDR_WIDTH-1:0];
    assign unused_addr_bits = ^full_addr[FULL_WIDTH-1:MEM_ADDR_WIDTH];

    always_comb begin
        cmd = CMD_NOP;
        if (bus.clock_enable && !bus.cs_n) begin
            cmd = cmd_t'({bus.ras_n, bus.cas_n, bus.we_n});
        end
    end

    always_comb begin
        state_d  = state_q;
        err_d    = 1'b0;
        do_act   = 1'b0;
        do_pre   = 1'b0;
        do_ref   = 1'b0;
        do_mrs   = 1'b0;
        do_read  = 1'b0;
        do_write = 1'b0;
        case (cmd)
            CMD_ACT: begin
                if (!ready || sel_open) err_d = 1'b1;
                else                    do_act = 1'b1;
            end
            CMD_READ: begin
                if (!ready || !sel_open) err_d = 1'b1;
                else                     do_read = 1'b1;
            end
            CMD_WRITE: begin
                if (!ready || !sel_open) begin
                    err_d = 1'b1;
                end else begin
                    // Bus contention with our own read beat is flagged but the write lands.
                    do_write = 1'b1;
                    err_d    = read_beat;
                end
            end
            CMD_PRE: begin
                do_pre = 1'b1;
                if (state_q == ST_WAIT_PALL && auto_pre) state_d = ST_WAIT_REF1;
            end
            CMD_REF: begin
                if (|bank_open) begin
                    err_d = 1'b1;
                end else begin
                    do_ref = 1'b1;
                    if (state_q == ST_WAIT_REF1)      state_d = ST_WAIT_REF2;
                    else if (state_q == ST_WAIT_REF2) state_d = ST_WAIT_MRS;
                end
            end
            CMD_MRS: begin
                if ((state_q == ST_WAIT_MRS || ready) && mode_legal(bus.addr[6:4], bus.addr[2:0])) begin
                    do_mrs  = 1'b1;
                    state_d = ST_READY;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_WAIT_PALL;
            bank_open     <= '0;
            cas_latency   <= 2'(CL_MAX);
            init_done     <= 1'b0;
            cmd_error     <= 1'b0;
            refresh_seen  <= 1'b0;
            refresh_count <= '0;
        end else begin
            state_q      <= state_d;
            init_done    <= ready;
            cmd_error    <= err_d;
            refresh_seen <= do_ref;
            if (refresh_seen) refresh_count <= refresh_count + 16'd1;
            if (do_mrs) cas_latency <= bus.addr[5:4];
            if (do_act) bank_open[bus.bank_addr] <= 1'b1;
            if (do_pre && auto_pre) begin
                bank_open <= '0;
            end else if (do_pre || ((do_read || do_write) && auto_pre)) begin
                bank_open[bus.bank_addr] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_act) bank_row[bus.bank_addr] <= bus.addr[ROW_WIDTH-1:0];
    end

    // Storage is deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (do_write) begin
            if (!bus.data_mask_low)  mem[mem_idx][7:0]  <= data[7:0];
            if (!bus.data_mask_high) mem[mem_idx][15:8] <= data[15:8];
        end
    end

    sdram_read_pipe u_read_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (do_read),
        .load_data   (mem[mem_idx]),
        .load_mask   ({bus.data_mask_high, bus.data_mask_low}),
        .cas_latency (cas_latency),
        .drive_en    (drive_en),
        .drive_data  (drive_data),
        .beat        (read_beat)
    );

    assign data[7:0]  = drive_en[0] ? drive_data[7:0]  : 8'hzz;
    assign data[15:8] = drive_en[1] ? drive_data[15:8] : 8'hzz;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder; DQ has pull-ups so a released bus reads 0xFFFF.
module tb_sdram_responder;
    import sdram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_wdata = 16'h0000;
    logic        init_done, cmd_error;
    logic [15:0] refresh_count;
    wire  [15:0] dq;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    sdram_if #(.BANK_WIDTH(2), .SDRADDR_WIDTH(13)) bus ();

    assign dq = tb_oe ? tb_wdata : 16'hzzzz;
    for (genvar i = 0; i < 16; i++) begin : g_pull
        pullup (dq[i]);
    end

    sdram_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .data          (dq),
        .init_done     (init_done),
        .cmd_error     (cmd_error),
        .refresh_count (refresh_count)
    );

    task automatic idle();
        bus.clock_enable   = 1'b1;
        bus.cs_n           = 1'b1;
        bus.ras_n          = 1'b1;
        bus.cas_n          = 1'b1;
        bus.we_n           = 1'b1;
        bus.bank_addr      = 2'd0;
        bus.addr           = 13'd0;
        bus.data_mask_low  = 1'b0;
        bus.data_mask_high = 1'b0;
        tb_oe              = 1'b0;
    endtask

    // Presents a command for one edge, returns 1 time unit after that edge.
    task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [15:0] wd, input logic ml, input logic mh);
        bus.cs_n           = 1'b0;
        {bus.ras_n, bus.cas_n, bus.we_n} = c;
        bus.bank_addr      = ba;
        bus.addr           = a;
        bus.data_mask_low  = ml;
        bus.data_mask_high = mh;
        tb_wdata           = wd;
        tb_oe              = (c == CMD_WRITE);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic nop(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (init_done !== 1'b0) $display("FAIL reset_init_done got=%b exp=0", init_done); else passed++;
        total++; if (cmd_error !== 1'b0) $display("FAIL reset_cmd_error got=%b exp=0", cmd_error); else passed++;
        total++; if (refresh_count !== 16'd0) $display("FAIL reset_refresh_count got=%0d exp=0", refresh_count); else passed++;
        total++; if (dq !== 16'hFFFF) $display("FAIL reset_dq_released got=%h exp=ffff", dq); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_init();
        issue(CMD_ACT, 2'd0, 13'h0001, 16'h0, 1'b0, 1'b0);
        total++; if (cmd_error !== 1'b1) $display("FAIL init_act_before_ready got=%b exp=1", cmd_error); else passed++;
        issue(CMD_PRE, 2'd0, 13'h0400, 16'h0, 1'b0, 1'b0);
        issue(CMD_REF, 2'd0, 13'h0000, 16'h0, 1'b0, 1'b0);
        issue(CMD_REF, 2'd0, 13'h0000, 16'h0, 1'b0, 1'b0);
        issue(CMD_MRS, 2'd0, 13'h0230, 16'h0, 1'b0, 1'b0);
        total++; if (cmd_error !== 1'b0) $display("FAIL init_mrs_error got=%b exp=0", cmd_error); else passed++;
        nop(1);
        total++; if (init_done !== 1'b1) $display("FAIL init_done got=%b exp=1", init_done); else passed++;
        total++; if (refresh_count !== 16'd2) $display("FAIL init_refresh_count got=%0d exp=2", refresh_count); else passed++;
    endtask

    task automatic test_write_read();
        issue(CMD_ACT, 2'd1, 13'h0005, 16'h0, 1'b0, 1'b0);
        issue(CMD_WRITE, 2'd1, 13'h0412, 16'hBEEF, 1'b0, 1'b0);
        issue(CMD_ACT, 2'd1, 13'h0005, 16'h0, 1'b0, 1'b0);
        total++; if (cmd_error !== 1'b0) $display("FAIL wr_autopre_reopen got=%b exp=0", cmd_error); else passed++;
        issue(CMD_READ, 2'd1, 13'h0412, 16'h0, 1'b0, 1'b0);
        nop(1);
        total++; if (dq !== 16'hFFFF) $display("FAIL rd_cl3_early got=%h exp=ffff", dq); else passed++;
        nop(1);
        total++; if (dq !== 16'hBEEF) $display("FAIL rd_cl3_beat got=%h exp=beef", dq); else passed++;
        nop(1);
        total++; if (dq !== 16'hFFFF) $display("FAIL rd_cl3_after got=%h exp=ffff", dq); else passed++;
        issue(CMD_READ, 2'd1, 13'h0012, 16'h0, 1'b0, 1'b0);
        total++; if (cmd_error !== 1'b1) $display("FAIL rd_autopre_closed got=%b exp=1", cmd_error); else passed++;
        nop(1);
        total++; if (cmd_error !== 1'b0) $display("FAIL cmd_error_one_cycle got=%b exp=0", cmd_error); else passed++;
        nop(3);
    endtask

    task automatic test_masked();
        issue(CMD_ACT, 2'd2, 13'h0003, 16'h0, 1'b0, 1'b0);
        issue(CMD_WRITE, 2'd2, 13'h0020, 16'h1234, 1'b0, 1'b0);
        issue(CMD_WRITE, 2'd2, 13'h0020, 16'hABCD, 1'b0, 1'b1);
        issue(CMD_READ, 2'd2, 13'h0420, 16'h0, 1'b0, 1'b0);
        nop(2);
        total++; if (dq !== 16'h12CD) $display("FAIL masked_write got=%h exp=12cd", dq); else passed++;
        nop(1);
        issue(CMD_ACT, 2'd2, 13'h0003, 16'h0, 1'b0, 1'b0);
        issue(CMD_READ, 2'd2, 13'h0420, 16'h0, 1'b1, 1'b0);
        nop(2);
        total++; if (dq !== 16'h12FF) $display("FAIL masked_read got=%h exp=12ff", dq); else passed++;
        nop(1);
        issue(CMD_MRS, 2'd0, 13'h0020, 16'h0, 1'b0, 1'b0);
        total++; if (cmd_error !== 1'b0) $display("FAIL mrs_cl2_error got=%b exp=0", cmd_error); else passed++;
        issue(CMD_ACT, 2'd2, 13'h0003, 16'h0, 1'b0, 1'b0);
        issue(CMD_READ, 2'd2, 13'h0420, 16'h0, 1'b0, 1'b0);
        nop(1);
        total++; if (dq !== 16'h12CD) $display("FAIL rd_cl2_beat got=%h exp=12cd", dq); else passed++;
        nop(1);
        total++; if (dq !== 16'hFFFF) $display("FAIL rd_cl2_after got=%h exp=ffff", dq); else passed++;
        issue(CMD_MRS, 2'd0, 13'h0030, 16'h0, 1'b0, 1'b0);
        nop(2);
    endtask

    task automatic test_violations();
        issue(CMD_ACT, 2'd0, 13'h0010, 16'h0, 1'b0, 1'b0);
        issue(CMD_WRITE, 2'd0, 13'h0005, 16'h5A5A, 1'b0, 1'b0);
        issue(CMD_ACT, 2'd0, 13'h0011, 16'h0, 1'b0, 1'b0);
        total++; if (cmd_error !== 1'b1) $display("FAIL act_open_bank got=%b exp=1", cmd_error); else passed++;
        issue(CMD_REF, 2'd0, 13'h0000, 16'h0, 1'b0, 1'b0);
        total++; if (cmd_error !== 1'b1) $display("FAIL ref_bank_open got=%b exp=1", cmd_error); else passed++;
        issue(CMD_MRS, 2'd0, 13'h0022, 16'h0, 1'b0, 1'b0);
        total++; if (cmd_error !== 1'b1) $display("FAIL mrs_bad_bl got=%b exp=1", cmd_error); else passed++;
        total++; if (refresh_count !== 16'd2) $display("FAIL ref_rejected_count got=%0d exp=2", refresh_count); else passed++;
        issue(CMD_READ, 2'd0, 13'h0405, 16'h0, 1'b0, 1'b0);
        total++; if (cmd_error !== 1'b0) $display("FAIL viol_read_error got=%b exp=0", cmd_error); else passed++;
        nop(1);
        total++; if (dq !== 16'hFFFF) $display("FAIL viol_cl_unchanged got=%h exp=ffff", dq); else passed++;
        nop(1);
        total++; if (dq !== 16'h5A5A) $display("FAIL viol_row_unchanged got=%h exp=5a5a", dq); else passed++;
        nop(1);
        issue(CMD_READ, 2'd0, 13'h0005, 16'h0, 1'b0, 1'b0);
        total++; if (cmd_error !== 1'b1) $display("FAIL read_closed_bank got=%b exp=1", cmd_error); else passed++;
        nop(3);
    endtask

    task automatic test_back_to_back();
        issue(CMD_ACT, 2'd3, 13'h0007, 16'h0, 1'b0, 1'b0);
        issue(CMD_WRITE, 2'd3, 13'h0000, 16'h1111, 1'b0, 1'b0);
        issue(CMD_WRITE, 2'd3, 13'h0001, 16'h2222, 1'b0, 1'b0);
        issue(CMD_WRITE, 2'd3, 13'h0002, 16'h3333, 1'b0, 1'b0);
        issue(CMD_READ, 2'd3, 13'h0000, 16'h0, 1'b0, 1'b0);
        issue(CMD_READ, 2'd3, 13'h0001, 16'h0, 1'b0, 1'b0);
        total++; if (dq !== 16'hFFFF) $display("FAIL b2b_early got=%h exp=ffff", dq); else passed++;
        issue(CMD_READ, 2'd3, 13'h0402, 16'h0, 1'b0, 1'b0);
        total++; if (dq !== 16'h1111) $display("FAIL b2b_beat0 got=%h exp=1111", dq); else passed++;
        nop(1);
        total++; if (dq !== 16'h2222) $display("FAIL b2b_beat1 got=%h exp=2222", dq); else passed++;
        nop(1);
        total++; if (dq !== 16'h3333) $display("FAIL b2b_beat2 got=%h exp=3333", dq); else passed++;
        nop(1);
        total++; if (dq !== 16'hFFFF) $display("FAIL b2b_after got=%h exp=ffff", dq); else passed++;
        nop(2);
    endtask

    task automatic test_reset_mid_read();
        issue(CMD_ACT, 2'd3, 13'h0007, 16'h0, 1'b0, 1'b0);
        issue(CMD_READ, 2'd3, 13'h0000, 16'h0, 1'b0, 1'b0);
        issue(CMD_READ, 2'd3, 13'h0001, 16'h0, 1'b0, 1'b0);
        issue(CMD_READ, 2'd3, 13'h0402, 16'h0, 1'b0, 1'b0);
        total++; if (dq !== 16'h1111) $display("FAIL midrst_beat got=%h exp=1111", dq); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (dq !== 16'hFFFF) $display("FAIL midrst_dq_released got=%h exp=ffff", dq); else passed++;
        total++; if (init_done !== 1'b0) $display("FAIL midrst_init_done got=%b exp=0", init_done); else passed++;
        total++; if (refresh_count !== 16'd0) $display("FAIL midrst_refresh_count got=%0d exp=0", refresh_count); else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_init();
        issue(CMD_ACT, 2'd1, 13'h0005, 16'h0, 1'b0, 1'b0);
        issue(CMD_READ, 2'd1, 13'h0412, 16'h0, 1'b0, 1'b0);
        nop(2);
        total++; if (dq !== 16'hBEEF) $display("FAIL midrst_mem_kept got=%h exp=beef", dq); else passed++;
        nop(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_masked();
        test_violations();
        test_back_to_back();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
